// File: rtl/clock_divider_pkg.sv
// Shared constants and helpers for the programmable clock divider.
package clock_divider_pkg;

  // Width of the divisor and of each channel counter when not overridden.
  localparam int CNT_W_DEFAULT = 8;

  // Divide ratio loaded into every channel at reset when not overridden.
  localparam int DEFAULT_DIV_VALUE = 4;

  // Smallest divide ratio that still yields a distinct low and high phase.
  localparam int MIN_DIV = 2;

  // Width of the channel-select field; never narrower than one bit.
  function automatic int sel_width(input int n_ch);
    return (n_ch <= 1) ? 1 : $clog2(n_ch);
  endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: period counter, active/pending divisor and the
// registered divided clock plus its rising-edge tick.
//
// Divisor changes are staged in d_pend and only reach d_act when the counter
// restarts (natural wrap, disable, or sync), so every emitted period is a
// complete period of a single divisor.
module clock_divider_channel
  import clock_divider_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int DEFAULT_DIV = DEFAULT_DIV_VALUE
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_value,
  output logic             clock_out,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] d_act;
  logic [CNT_W-1:0] d_pend;

  logic [CNT_W-1:0] d_pend_nxt;
  logic [CNT_W-1:0] d_act_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] half_nxt;
  logic             wrap;
  logic             restart;

  // Next-state decode: restart the period on disable, sync or natural wrap
  // and pick up the (possibly just written) pending divisor at that moment.
  always_comb begin
    d_pend_nxt = wr ? wr_value : d_pend;
    wrap       = (cnt >= (d_act - CNT_W'(1)));
    restart    = !enable || sync || wrap;
    cnt_nxt    = cnt + CNT_W'(1);
    d_act_nxt  = d_act;
    if (restart) begin
      cnt_nxt   = '0;
      d_act_nxt = d_pend_nxt;
    end
    // ceil(D/2) without needing an extra carry bit.
    half_nxt = (d_act_nxt >> 1) + {{(CNT_W-1){1'b0}}, d_act_nxt[0]};
  end

  // State and output registers; outputs come from next state so they are flops.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      cnt       <= '0;
      d_act     <= CNT_W'(DEFAULT_DIV);
      d_pend    <= CNT_W'(DEFAULT_DIV);
      clock_out <= 1'b0;
      tick      <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      d_act     <= d_act_nxt;
      d_pend    <= d_pend_nxt;
      clock_out <= enable && (cnt_nxt >= half_nxt);
      tick      <= enable && (cnt_nxt == half_nxt);
    end
  end

endmodule

// File: rtl/programmable_clock_divider.sv
// Multi-channel programmable clock divider. This level only decodes and
// range-checks divisor writes and reports rejected ones; all timing lives in
// the per-channel instances.
//
// Write port: div_load is a single-cycle strobe with no backpressure. In the
// cycle it is high, div_sel/div_value are sampled; the write either lands in
// the selected channel's pending divisor or is dropped and load_err pulses for
// exactly one cycle afterwards. There is no ready signal: every strobe is
// consumed in its own cycle.
module programmable_clock_divider
  import clock_divider_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int DEFAULT_DIV = DEFAULT_DIV_VALUE,
  localparam int SEL_W      = sel_width(N_CH)
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic [N_CH-1:0]  enable,
  input  logic             sync,
  input  logic             div_load,
  input  logic [SEL_W-1:0] div_sel,
  input  logic [CNT_W-1:0] div_value,
  output logic [N_CH-1:0]  clock_out,
  output logic [N_CH-1:0]  tick,
  output logic             load_err
);

  logic            sel_ok;
  logic            value_ok;
  logic            write_ok;
  logic [N_CH-1:0] wr;

  // Range check and one-hot decode of the shared write port.
  always_comb begin
    sel_ok   = (int'(div_sel) < N_CH);
    value_ok = (div_value >= CNT_W'(MIN_DIV));
    write_ok = div_load && sel_ok && value_ok;
    for (int i = 0; i < N_CH; i++) begin
      wr[i] = write_ok && (int'(div_sel) == i);
    end
  end

  // Flag a rejected write for one cycle.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      load_err <= 1'b0;
    end else begin
      load_err <= div_load && !write_ok;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    clock_divider_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clock_in  (clock_in),
      .reset     (reset),
      .enable    (enable[g]),
      .sync      (sync),
      .wr        (wr[g]),
      .wr_value  (div_value),
      .clock_out (clock_out[g]),
      .tick      (tick[g])
    );
  end

endmodule

// File: tb/tb_programmable_clock_divider.sv
// Bench for programmable_clock_divider. Five channels are used so that a
// select equal to the channel count is expressible on the 3-bit select port.
// The reference model tracks, per channel, the cycle at which the current
// period started and its divisor; expected outputs follow from the position
// inside the period by plain modular arithmetic.
module tb_programmable_clock_divider;

  localparam int N_CH    = 5;
  localparam int CNT_W   = 8;
  localparam int DEF_DIV = 4;
  localparam int SEL_W   = 3;
  localparam int W       = 2 * N_CH + 1;

  logic             clock_in = 1'b0;
  logic             reset;
  logic [N_CH-1:0]  enable;
  logic             sync;
  logic             div_load;
  logic [SEL_W-1:0] div_sel;
  logic [CNT_W-1:0] div_value;
  logic [N_CH-1:0]  clock_out;
  logic [N_CH-1:0]  tick;
  logic             load_err;

  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboard: expected {clock_out, tick, load_err} per cycle.
  logic [W-1:0] exp_q[$];

  // Reference model state.
  int   m_act[N_CH];
  int   m_pend[N_CH];
  int   m_start[N_CH];
  int   cyc   = 0;
  logic m_err = 1'b0;

  programmable_clock_divider #(
    .N_CH        (N_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEF_DIV)
  ) dut (
    .clock_in  (clock_in),
    .reset     (reset),
    .enable    (enable),
    .sync      (sync),
    .div_load  (div_load),
    .div_sel   (div_sel),
    .div_value (div_value),
    .clock_out (clock_out),
    .tick      (tick),
    .load_err  (load_err)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clock_in = ~clock_in;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic int phase(input int ch);
    return (cyc - m_start[ch]) % m_act[ch];
  endfunction

  // Apply the inputs present at this rising edge.
  task automatic model_edge();
    bit bad;
    int pn;
    if (reset) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        m_act[ch]   = DEF_DIV;
        m_pend[ch]  = DEF_DIV;
        m_start[ch] = cyc + 1;
      end
      m_err = 1'b0;
    end else begin
      bad   = div_load && ((int'(div_value) < 2) || (int'(div_sel) >= N_CH));
      m_err = bad;
      for (int ch = 0; ch < N_CH; ch++) begin
        pn = (div_load && !bad && (int'(div_sel) == ch)) ? int'(div_value) : m_pend[ch];
        m_pend[ch] = pn;
        if (!enable[ch] || sync || (phase(ch) == m_act[ch] - 1)) begin
          m_act[ch]   = pn;
          m_start[ch] = cyc + 1;
        end
      end
    end
    cyc++;
  endtask

  function automatic logic [W-1:0] model_out();
    logic [N_CH-1:0] c;
    logic [N_CH-1:0] t;
    int p;
    int h;
    for (int ch = 0; ch < N_CH; ch++) begin
      p     = phase(ch);
      h     = (m_act[ch] + 1) / 2;
      c[ch] = (p >= h);
      t[ch] = (p == h);
    end
    return {c, t, m_err};
  endfunction

  task automatic scoreboard();
    logic [W-1:0] e;
    e = exp_q.pop_front();
    check("clock_out", 32'(clock_out), 32'(e[W-1:N_CH+1]));
    check("tick", 32'(tick), 32'(e[N_CH:1]));
    check("load_err", 32'(load_err), 32'(e[0]));
    check("tick_while_low", 32'(tick & ~clock_out), 32'(0));
  endtask

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clock_in);
    model_edge();
    exp_q.push_back(model_out());
    #1;
    scoreboard();
  endtask

  task automatic do_write(input int sel, input int val);
    div_load  = 1'b1;
    div_sel   = SEL_W'(sel);
    div_value = CNT_W'(val);
    step();
    div_load  = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  int first_rise[4];
  int n_ticks;
  int n_high;

  initial begin
    for (int ch = 0; ch < N_CH; ch++) begin
      m_act[ch]   = DEF_DIV;
      m_pend[ch]  = DEF_DIV;
      m_start[ch] = 0;
    end
    reset = 1'b1; enable = '0; sync = 1'b0;
    div_load = 1'b0; div_sel = '0; div_value = '0;
    step();
    step();
    check("reset_clock_out", 32'(clock_out), 32'(0));
    check("reset_tick", 32'(tick), 32'(0));
    check("reset_load_err", 32'(load_err), 32'(0));

    // Default divide-by-4 on channel 0: 0,0,1,1 with ticks on cycles 2,6,10.
    reset  = 1'b0;
    enable = 5'b00001;
    for (int i = 0; i < 12; i++) begin
      check("d4_pattern", 32'(clock_out[0]), 32'((i % 4) >= 2));
      check("d4_tick", 32'(tick[0]), 32'((i == 2) || (i == 6) || (i == 10)));
      step();
    end

    // Channel 1: write D=5 in the high phase of a D=4 period.
    enable = 5'b00011;
    step();
    step();
    do_write(1, 5);
    check("d5_old_period_completes", 32'(clock_out[1]), 32'(1));
    n_ticks = 0;
    n_high  = 0;
    for (int i = 0; i < 15; i++) begin
      n_ticks += int'(tick[1]);
      n_high  += int'(clock_out[1]);
      step();
    end
    check("d5_tick_count", 32'(n_ticks), 32'(3));
    check("d5_high_count", 32'(n_high), 32'(6));

    // Rejected writes: ratio below minimum, then out-of-range channel.
    div_load = 1'b1; div_sel = 3'd0; div_value = 8'd1;
    step();
    div_load = 1'b0;
    check("err_small_value", 32'(load_err), 32'(1));
    step();
    check("err_clears_1", 32'(load_err), 32'(0));
    div_load = 1'b1; div_sel = 3'd5; div_value = 8'd7;
    step();
    div_load = 1'b0;
    check("err_bad_sel", 32'(load_err), 32'(1));
    step();
    check("err_clears_2", 32'(load_err), 32'(0));

    // Sync alignment with D = 2, 3, 6, 255.
    do_write(0, 2);
    do_write(1, 3);
    do_write(2, 6);
    do_write(3, 255);
    enable = 5'b01111;
    sync   = 1'b1;
    step();
    sync   = 1'b0;
    check("sync_all_low", 32'(clock_out[3:0]), 32'(0));
    for (int ch = 0; ch < 4; ch++) first_rise[ch] = -1;
    for (int k = 0; k < 140; k++) begin
      for (int ch = 0; ch < 4; ch++) begin
        if (first_rise[ch] < 0 && clock_out[ch]) first_rise[ch] = k;
      end
      step();
    end
    check("sync_rise_d2", 32'(first_rise[0]), 32'(1));
    check("sync_rise_d3", 32'(first_rise[1]), 32'(2));
    check("sync_rise_d6", 32'(first_rise[2]), 32'(3));
    check("sync_rise_d255", 32'(first_rise[3]), 32'(128));

    // Drop channel 2 in its high phase, restore after 7 cycles.
    for (int k = 0; k < 20 && !clock_out[2]; k++) step();
    check("ch2_high_found", 32'(clock_out[2]), 32'(1));
    enable[2] = 1'b0;
    step();
    check("ch2_drop_low", 32'(clock_out[2]), 32'(0));
    repeat (6) step();
    enable[2] = 1'b1;
    for (int i = 0; i < 9; i++) begin
      check("ch2_restart", 32'(clock_out[2]), 32'((i % 6) >= 3));
      step();
    end

    // Randomized traffic checked against the model every cycle.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) enable = N_CH'($urandom);
      sync      = ($urandom_range(0, 19) == 0);
      div_load  = ($urandom_range(0, 3) == 0);
      div_sel   = ($urandom_range(0, 9) == 0) ? SEL_W'($urandom_range(0, 7))
                                              : SEL_W'($urandom_range(0, N_CH - 1));
      div_value = ($urandom_range(0, 5) == 0) ? CNT_W'($urandom)
                                              : CNT_W'($urandom_range(0, 12));
      reset     = ($urandom_range(0, 149) == 0);
      step();
    end
    reset = 1'b0; sync = 1'b0; div_load = 1'b0;

    // Reset mid-period with a pending write: default ratio afterwards.
    enable = 5'b00001;
    sync   = 1'b1;
    step();
    sync   = 1'b0;
    step();
    do_write(0, 9);
    reset = 1'b1;
    step();
    check("rst_clock_out", 32'(clock_out), 32'(0));
    check("rst_tick", 32'(tick), 32'(0));
    check("rst_load_err", 32'(load_err), 32'(0));
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("rst_default_pattern", 32'(clock_out[0]), 32'((i % 4) >= 2));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/programmable_clock_divider.md
PROGRAMMABLE_CLOCK_DIVIDER -- requirements
Module: programmable_clock_divider

Interface
REQ-001 Parameter N_CH, default 4: number of independent divider channels (1..16).
REQ-002 Parameter CNT_W, default 8: divisor and counter width in bits.
REQ-003 Parameter DEFAULT_DIV, default 4: divide ratio loaded into every channel at reset.
REQ-004 clock_in  input  1  sole clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  N_CH  per-channel run enable.
REQ-007 sync  input  1  single-cycle pulse; phase-aligns all channels.
REQ-008 div_load  input  1  single-cycle divisor write strobe.
REQ-009 div_sel  input  clog2(N_CH) (min 1)  target channel of the write.
REQ-010 div_value  input  CNT_W  requested divide ratio D.
REQ-011 clock_out  output  N_CH  registered divided clocks.
REQ-012 tick  output  N_CH  registered one-cycle pulse, coincident with each clock_out rising edge.
REQ-013 load_err  output  1  registered one-cycle pulse flagging a rejected write.

Function
REQ-014 Each channel holds active divisor D_act, pending divisor D_pend and counter cnt (CNT_W bits).
REQ-015 Enabled channel: cnt increments every cycle; when cnt == D_act-1, cnt wraps to 0 on the next edge.
REQ-016 Output period is exactly D_act cycles: clock_out low for ceil(D_act/2) cycles, then high for floor(D_act/2) cycles; clock_out = (cnt >= ceil(D_act/2)), computed from next state so it is a flop.
REQ-017 tick is 1 exactly in the first cycle of each high phase; never asserted while clock_out is low.
REQ-018 Valid D range is 2..2^CNT_W-1; div_value < 2 or div_sel >= N_CH: write discarded, load_err = 1 the following cycle, no state change.
REQ-019 Valid write updates D_pend of channel div_sel; a second write before it applies overwrites it (last wins).
REQ-020 D_pend is copied to D_act only at a period boundary (cycle in which cnt wraps to 0), when the channel is disabled, or on sync; no partial or runt period is ever produced.
REQ-021 Write and boundary in the same cycle: the new value becomes D_act at that boundary.
REQ-022 enable low: cnt <= 0, clock_out <= 0, tick <= 0 on the next edge and held; D_pend applies immediately.
REQ-023 enable rising: first cycle has cnt = 0, clock_out low; first rising edge after ceil(D_act/2) cycles.
REQ-024 sync: every channel cnt <= 0, clock_out <= 0, D_act <= D_pend on the next edge; a write in the same cycle as sync is included.
REQ-025 sync has priority over the natural boundary; disable has priority over sync for that channel.
REQ-026 Channels are fully independent except for sync and the shared write port.

Reset
REQ-027 reset: every cnt = 0, clock_out = 0, tick = 0, load_err = 0, D_act = D_pend = DEFAULT_DIV on the next edge.
REQ-028 reset dominates all other inputs; reset mid-period discards the period and any pending write.
REQ-029 First cycle after reset release behaves as REQ-023 for enabled channels.

Structure
REQ-030 Package clock_divider_pkg holds CNT_W default, DEFAULT_DIV, MIN_DIV = 2 and the channel-select width function.
REQ-031 Sub-module clock_divider_channel implements one channel (counter, D_act/D_pend, clock_out, tick), instantiated N_CH times by generate.
REQ-032 Top level holds only write decode, range check and the load_err flop.
REQ-033 clock_out is a logic signal for enable/timing use, never used as a clock inside the block.

Verification
REQ-034 Reset, enable[0] = 1, default D = 4 -> clock_out[0] pattern 0,0,1,1 repeating; tick[0] on cycles 2, 6, 10.
REQ-035 Write D = 5 to channel 1 mid-period -> current D = 4 period completes, then low 3 and high 2 cycles; one tick per 5 cycles.
REQ-036 Writes with div_value = 1, then div_sel = N_CH -> load_err pulses once each, all outputs unchanged.
REQ-037 Channels 0..3 at D = 2, 3, 6, 255; sync pulse -> all clock_out low the next cycle; rising edges 1, 2, 3, 128 cycles later.
REQ-038 enable[2] dropped in a high phase, restored 7 cycles later -> clock_out[2] low the next cycle; restarts per REQ-023 with no runt pulse.
REQ-039 reset asserted with a pending write and mid-period -> all outputs 0 the next cycle; D_act = DEFAULT_DIV after release.
